// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 32-bit PRBS (taps 31,30,29,27,25,0): fill, search, then flywheel lock.
// Counts bit errors and checked bits with saturation, and drops lock when one window holds too many errors.
module prbs_checker #(
  parameter int LOCK_LEN  = 32,
  parameter int LOSS_WIN  = 64,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int WB_W = $clog2(LOSS_WIN);
  localparam int WE_W = $clog2(LOSS_ERRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

  state_t           state, state_n;
  logic [31:0]      h, h_n;
  logic [7:0]       good_cnt, good_n, good_inc;
  logic [WB_W-1:0]  win_bits, win_bits_n;
  logic [WE_W-1:0]  win_errs, win_errs_n, errs_inc;
  logic             locked_n, err_pulse_n;
  logic [CNT_W-1:0] err_count_n, bit_count_n;
  logic             pred, mismatch;

  assign pred     = h[31] ^ h[30] ^ h[29] ^ h[27] ^ h[25] ^ h[0];
  assign mismatch = in_bit ^ pred;
  assign good_inc = good_cnt + 8'd1;
  assign errs_inc = win_errs + WE_W'(mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      h         <= '0;
      good_cnt  <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      good_cnt  <= good_n;
      win_bits  <= win_bits_n;
      win_errs  <= win_errs_n;
      locked    <= locked_n;
      err_pulse <= err_pulse_n;
      err_count <= err_count_n;
      bit_count <= bit_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    h_n         = h;
    good_n      = good_cnt;
    win_bits_n  = win_bits;
    win_errs_n  = win_errs;
    err_pulse_n = 1'b0;
    err_count_n = err_count;
    bit_count_n = bit_count;

    if (enable) begin
      case (state)
        FILL: begin
          // good_cnt doubles as the fill counter; it is re-zeroed on entry to SEARCH
          h_n = {in_bit, h[31:1]};
          if (good_cnt == 8'd31) begin
            state_n = SEARCH;
            good_n  = '0;
          end else begin
            good_n = good_inc;
          end
        end
        SEARCH: begin
          h_n = {in_bit, h[31:1]};
          // an all-zero history would trivially predict zeros, so it never counts
          if (!mismatch && (h != '0)) begin
            if (good_inc == 8'(LOCK_LEN)) begin
              state_n    = LOCKED;
              good_n     = '0;
              win_bits_n = '0;
              win_errs_n = '0;
            end else begin
              good_n = good_inc;
            end
          end else begin
            good_n = '0;
          end
        end
        LOCKED: begin
          // flywheel: feed back the prediction so a line error never corrupts the history
          h_n         = {pred, h[31:1]};
          err_pulse_n = mismatch;
          if (mismatch && (err_count != CNT_MAX)) err_count_n = err_count + CNT_W'(1);
          if (bit_count != CNT_MAX) bit_count_n = bit_count + CNT_W'(1);
          if (errs_inc == WE_W'(LOSS_ERRS)) begin
            state_n    = FILL;
            good_n     = '0;
            win_bits_n = '0;
            win_errs_n = '0;
          end else if (win_bits == WB_W'(LOSS_WIN - 1)) begin
            win_bits_n = '0;
            win_errs_n = '0;
          end else begin
            win_bits_n = win_bits + WB_W'(1);
            win_errs_n = errs_inc;
          end
        end
        default: state_n = FILL;
      endcase
    end

    if (clear) begin
      err_count_n = '0;
      bit_count_n = '0;
    end

    locked_n = (state_n == LOCKED);
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial checker for the 32-bit PRBS stream produced by the team's LFSR generator, using taps 31, 30, 29, 27, 25 and 0. The generator's transmitted bit is its shift_reg[0], one bit per enabled cycle. This block sits at the receive end of a link or loopback path. It self-synchronises to the incoming stream, declares lock, counts bit errors and received bits, and drops lock when the error rate is too high.

## Interface
Parameters:
- LOCK_LEN, default 32: number of consecutive correct predictions in SEARCH needed to declare lock (1..255).
- LOSS_WIN, default 64: error-rate window in enabled bits while LOCKED (2..65535).
- LOSS_ERRS, default 8: number of errors within one window that drops lock (1..LOSS_WIN).
- CNT_W, default 32: width of err_count and bit_count.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: in_bit is valid this cycle.
- in_bit, input, 1: received PRBS bit.
- clear, input, 1: synchronous clear of err_count and bit_count.
- locked, output, 1: checker is synchronised.
- err_pulse, output, 1: one-cycle strobe marking a bit error detected while LOCKED.
- err_count, output, CNT_W: saturating error count.
- bit_count, output, CNT_W: saturating count of bits checked while LOCKED.

## Operation
- History register h[31:0] shifts right on every enabled bit. Its new MSB is the shift-in bit (defined per state below).
- Prediction: pred = h[31]^h[30]^h[29]^h[27]^h[25]^h[0]. This is the same recurrence as the generator. After 32 received bits, pred equals the next expected in_bit.
- States:
  - FILL (reset state): shift in in_bit. After 32 enabled bits, go to SEARCH with good_cnt=0.
  - SEARCH: shift in in_bit (self-synchronising). If in_bit==pred and h is not all-zero, increment good_cnt. Otherwise, clear good_cnt.
    - An all-zero history never counts as a match. This blocks false lock on a stuck-at-0 line.
    - When good_cnt reaches LOCK_LEN on a bit, go to LOCKED and clear the window counters.
  - LOCKED (flywheel): shift in pred, not in_bit, so one line error is counted exactly once. Mismatch handling:
    - err_pulse=1 on the next cycle.
    - err_count increments.
    - win_errs increments.
  - LOCKED, every enabled bit: bit_count increments, and win_bits increments.
  - LOCKED, window end: when win_bits wraps at LOSS_WIN-1→0, win_errs is cleared.
  - LOCKED, loss of lock: if win_errs reaches LOSS_ERRS, go to FILL. The loss takes effect on that bit even if it is also the window-wrap bit. The counters are retained.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear zeros err_count and bit_count. If clear coincides with an increment, clear wins and the count is 0. err_pulse still fires. clear has no effect on state, h, or window counters.
- While enable=0: nothing changes and err_pulse=0.

## Timing
- Reset values:
  - state=FILL, h=0, good_cnt=0, win_bits=0, win_errs=0.
  - locked=0, err_pulse=0, err_count=0, bit_count=0.
- All outputs are registered and update on the rising edge that samples the bit.
- locked rises on the edge sampling the LOCK_LEN-th good bit in SEARCH. That bit is not counted in bit_count.
- With a clean stream, locked rises on the edge of enabled bit 32+LOCK_LEN (bit 64 at default). Gaps in enable add no state.
- locked falls on the edge sampling the loss-triggering bit. That bit is still counted in err_count and bit_count, and err_pulse fires.
- err_pulse is high for exactly the one cycle following the error edge. Back-to-back errors on consecutive enabled cycles produce a continuous high.
- rst asserted mid-operation returns every register to its reset value immediately. This is asynchronous and needs no clock.

## Test plan
- Reset, then clean generator stream (seed 32'h00000001, enable every cycle) → locked=0 through bit 63. locked=1 after bit 64. err_count=0. bit_count=N-64 after N bits.
- Locked, flip bit at index 100 → err_pulse high exactly one cycle. err_count=1. locked stays 1. No further errors on following bits.
- Locked, flip 8 bits inside one 64-bit window → locked=0 on the 8th error edge. err_count=8. Clean stream afterwards relocks after 64 more bits.
- Locked, 7 errors in one window then 7 in the next → locked stays 1. err_count=14.
- in_bit held 0 (and separately all-1s) for 1000 bits → locked never asserts.
- clear on the same edge as an error → err_count=0 and err_pulse=1. Also: rst mid-lock → all outputs 0 at once, then relock after 64 clean bits. Also: toggling enable with gaps → lock point unchanged in bit count.
